// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared BCD types, constants and helpers for the BCD datapaths.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_ADJ = 4'd3;
    localparam logic [3:0] BCD_THR = 4'd8;

    function automatic logic digit_is_valid(input logic [3:0] nibble);
        return (nibble <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adjust
// Purpose  : One-digit correction cell for reverse double-dabble (>=8 -> -3).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_THR) ? (digit_i - BCD_ADJ) : digit_i;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_seq
// Purpose  : Sequential packed-BCD to binary converter (reverse double-dabble).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    bcd_state_t          state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [BIN_W-1:0]    bin_q, bin_d;

    logic [WORK_W-1:0]   work_shift;
    logic [BCD_W-1:0]    adj_field;
    logic [WORK_W-1:0]   work_step;
    logic                in_valid;

    // One iteration: shift the whole register right, then correct each BCD digit.
    assign work_shift = work_q >> 1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_i (work_shift[BIN_W + 4*gi +: 4]),
                .digit_o (adj_field[4*gi +: 4])
            );
        end
    endgenerate

    assign work_step = {adj_field, work_shift[BIN_W-1:0]};

    always_comb begin
        in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_is_valid(bcd_in[4*i +: 4])) begin
                in_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in_valid) begin
                        work_d  = {bcd_in, {BIN_W{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = SHIFT;
                    end else begin
                        // Bad digit: report immediately, no iterations run.
                        err_d   = 1'b1;
                        bin_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = work_step[BIN_W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            bin_q   <= bin_d;
        end
    end

    assign busy    = (state_q == SHIFT);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule
`default_nettype wire

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter: the reverse of the team's BCD adder path, turning packed BCD results back into plain binary for downstream arithmetic and display logic. It accepts a DIGITS-digit packed BCD word on a start pulse and runs a reverse double-dabble (shift-right / subtract-3) over BIN_W cycles. It presents the binary result with a one-cycle done strobe, and flags any non-decimal input digit.

## Interface
- DIGITS, 4, number of packed BCD digits on bcd_in
- BIN_W, 14, result width and iteration count; must satisfy 2^BIN_W > 10^DIGITS - 1
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous and active-high
- start  input  1  request a conversion; sampled only in IDLE
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in bits [3:0]; sampled on the accepting edge
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle strobe, result or error valid
- err  output  1  high with done when any input digit > 9; held until the next accepted start
- bin_out  output  BIN_W  binary result; held until the next accepted start

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, all digits ≤ 9:
  - Load work register {bcd_in, BIN_W'b0}, clear cnt and err, go to SHIFT.
- IDLE, start=1, any digit > 9:
  - Set err=1, bin_out=0, go to DONE with no shifting.
- IDLE, start=0: stay.
- SHIFT, each edge:
  - Shift the whole work register right by 1.
  - Then every 4-bit BCD digit whose value is ≥ 8 has 3 subtracted (mod 16, per digit, no inter-digit borrow).
  - Increment cnt.
- When cnt reaches BIN_W-1, that edge performs the final shift, loads bin_out from the low BIN_W bits, and moves to DONE.
- DONE: done=1 for that cycle; unconditionally go to IDLE on the next edge.
- start in SHIFT or DONE is ignored, not queued.
- After BIN_W shifts, the BCD field of the work register is all zero. A non-zero field is an implementation bug; the bench checks it via hierarchy.
- Arithmetic: result equals Σ digit_i·10^i, exact for all valid inputs, range 0 … 10^DIGITS-1.

## Timing
- Reset, taking effect at the next rising edge:
  - state=IDLE; busy=0, done=0, err=0; bin_out=0, cnt=0, work register 0.
- Reset mid-conversion aborts at the next edge with the same values; no done is produced.
- Accepting edge E (IDLE, start=1, valid input):
  - busy=1 from E through E+BIN_W-1, i.e. BIN_W cycles.
  - done=1 in the cycle after edge E+BIN_W.
  - Earliest next accept is edge E+BIN_W+2.
- Accepting edge E with an invalid digit: done=1 and err=1 in the cycle after E; busy never rises.
- done and busy are never high together.
- bin_out and err are stable from the done cycle until the next accepting edge.
- start held high continuously: conversions run back-to-back with one IDLE cycle between them.

## Structure
- Shared package bcd_pkg:
  - State enum (IDLE/SHIFT/DONE).
  - Function digit_is_valid(nibble).
  - Constant BCD_ADJ = 3 and threshold BCD_THR = 8.
  - Later reused by the adder and a binary-to-BCD block.
- One natural sub-module: bcd_digit_adjust. It is a combinational 4-bit in / 4-bit out ≥8→−3 cell, instantiated DIGITS times in a generate loop.
- Top: FSM, cnt of width $clog2(BIN_W+1), work register of width 4*DIGITS+BIN_W, output registers.

## Test plan
- bcd_in=16'h1234, start 1 cycle → busy for 14 cycles, then done=1, bin_out=1234 (0x04D2), err=0.
- bcd_in=16'h9999 → bin_out=9999 (0x270F); bcd_in=16'h0000 → bin_out=0. Both with latency exactly BIN_W to done.
- bcd_in=16'h12A4 → done and err=1 one cycle after the accepting edge, bin_out=0, busy stays 0. A following valid 16'h0042 → err=0, bin_out=42.
- Start 16'h0500, pulse start again with 16'h9999 at cycle 5 of SHIFT → ignored; result 500, exactly one done.
- Assert rst in SHIFT cycle 7 → next edge all outputs 0, no done. A fresh 16'h0099 start converts to 99 normally.
- Exhaustive sweep of all 10^4 valid inputs, start held high → each done carries the correct value; done spacing is BIN_W+2 cycles.
